pipe_skid_stage: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, an optional two-entry skid buffer, and a synchronous flush that turns the stage into a bubble while carrying the PC through. It replaces the fixed-field, stall-by-bubble stage registers between IF/ID/EX/MEM. It is placed on any stage boundary: payload width and bubble encoding are parameters, and back-pressure is a real handshake instead of a global stall vector.

---
 rtl/pipe_skid_stage.sv | 102 ++++++++++
 tb/tb_pipe_skid_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - pipeline stage register with valid/ready handshake, optional skid buffer and flush
module pipe_skid_stage #(
  parameter int                  DATA_W  = 96,
  parameter int                  PC_W    = 32,
  parameter logic [DATA_W-1:0]   NOP_VAL = {DATA_W{1'b0}},
  parameter int                  SKID    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [PC_W-1:0]   up_pc_i,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [PC_W-1:0]   dn_pc_o,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [1:0]        count_o
);

  logic              m_valid;
  logic [PC_W-1:0]   m_pc;
  logic [DATA_W-1:0] m_data;
  logic              s_valid;
  logic              acc;
  logic              xfer;

  assign acc        = up_valid_i & up_ready_o;
  assign xfer       = m_valid & dn_ready_i;
  assign dn_valid_o = m_valid;
  assign dn_pc_o    = m_pc;
  assign dn_data_o  = m_data;
  assign count_o    = {1'b0, m_valid} + {1'b0, s_valid};

  generate
    if (SKID != 0) begin : g_skid
      logic [PC_W-1:0]   s_pc;
      logic [DATA_W-1:0] s_data;

      // Ready comes straight from a flop, so no path from dn_ready_i reaches upstream.
      assign up_ready_o = ~s_valid;

      always_ff @(posedge clk) begin
        if (!rst) begin
          m_valid <= 1'b0;
          m_pc    <= '0;
          m_data  <= NOP_VAL;
          s_valid <= 1'b0;
          s_pc    <= '0;
          s_data  <= NOP_VAL;
        end else if (flush_i) begin
          // The PC is carried through so the bubble still reports where it came from.
          m_valid <= 1'b0;
          m_pc    <= up_pc_i;
          m_data  <= NOP_VAL;
          s_valid <= 1'b0;
        end else if (s_valid) begin
          if (xfer) begin
            m_pc    <= s_pc;
            m_data  <= s_data;
            s_valid <= 1'b0;
          end
        end else if (acc) begin
          if (!m_valid || xfer) begin
            m_valid <= 1'b1;
            m_pc    <= up_pc_i;
            m_data  <= up_data_i;
          end else begin
            s_valid <= 1'b1;
            s_pc    <= up_pc_i;
            s_data  <= up_data_i;
          end
        end else if (xfer) begin
          m_valid <= 1'b0;
        end
      end
    end else begin : g_single
      assign s_valid    = 1'b0;
      assign up_ready_o = ~m_valid | dn_ready_i;

      always_ff @(posedge clk) begin
        if (!rst) begin
          m_valid <= 1'b0;
          m_pc    <= '0;
          m_data  <= NOP_VAL;
        end else if (flush_i) begin
          m_valid <= 1'b0;
          m_pc    <= up_pc_i;
          m_data  <= NOP_VAL;
        end else if (acc) begin
          m_valid <= 1'b1;
          m_pc    <= up_pc_i;
          m_data  <= up_data_i;
        end else if (xfer) begin
          m_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - randomized queue-model bench for pipe_skid_stage, both SKID settings
module tb_pipe_skid_stage;
  localparam int DW = 32;
  localparam int PW = 32;
  localparam logic [DW-1:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush_i, up_valid_i, dn_ready_i;
  logic [PW-1:0] up_pc_i;
  logic [DW-1:0] up_data_i;

  logic          up_ready1, dn_valid1, up_ready0, dn_valid0;
  logic [PW-1:0] dn_pc1, dn_pc0;
  logic [DW-1:0] dn_data1, dn_data0;
  logic [1:0]    count1, count0;

  pipe_skid_stage #(.DATA_W(DW), .PC_W(PW), .NOP_VAL(NOP), .SKID(1)) u_skid (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .up_valid_i(up_valid_i), .up_ready_o(up_ready1), .up_pc_i(up_pc_i), .up_data_i(up_data_i),
    .dn_valid_o(dn_valid1), .dn_ready_i(dn_ready_i), .dn_pc_o(dn_pc1), .dn_data_o(dn_data1),
    .count_o(count1)
  );

  pipe_skid_stage #(.DATA_W(DW), .PC_W(PW), .NOP_VAL(NOP), .SKID(0)) u_single (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .up_valid_i(up_valid_i), .up_ready_o(up_ready0), .up_pc_i(up_pc_i), .up_data_i(up_data_i),
    .dn_valid_o(dn_valid0), .dn_ready_i(dn_ready_i), .dn_pc_o(dn_pc0), .dn_data_o(dn_data0),
    .count_o(count0)
  );

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [DW-1:0] data;
  } beat_t;

  // Reference: the stage is a FIFO of depth 2 (SKID=1) or 1 (SKID=0), emptied by flush/reset.
  beat_t         q[$];
  bit            sel_skid;
  bit            model_ok;
  bit            idle_known;
  logic [PW-1:0] idle_pc;
  logic [DW-1:0] idle_data;
  bit            last_acc;
  int            obs_delivered;
  logic [PW-1:0] last_obs_pc;

  bit            src_valid;
  logic [PW-1:0] src_pc;
  logic [DW-1:0] src_data;
  logic [PW-1:0] next_pc;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic f, input logic uv,
                       input logic [PW-1:0] pc, input logic [DW-1:0] d, input logic dr);
    logic          o_ready, o_valid;
    logic [PW-1:0] o_pc;
    logic [DW-1:0] o_data;
    logic [1:0]    o_cnt;
    bit            exp_ready, acc, xfer;
    rst = r; flush_i = f; up_valid_i = uv; up_pc_i = pc; up_data_i = d; dn_ready_i = dr;
    #1;
    if (sel_skid) begin
      o_ready = up_ready1; o_valid = dn_valid1; o_pc = dn_pc1; o_data = dn_data1; o_cnt = count1;
    end else begin
      o_ready = up_ready0; o_valid = dn_valid0; o_pc = dn_pc0; o_data = dn_data0; o_cnt = count0;
    end
    exp_ready = sel_skid ? (q.size() < 2) : (q.size() == 0 || dr);
    acc  = uv && exp_ready;
    xfer = (q.size() > 0) && dr;
    if (model_ok) begin
      check("up_ready", o_ready, exp_ready);
      check("dn_valid", o_valid, q.size() > 0);
      check("count", o_cnt, q.size());
      if (q.size() > 0) begin
        check("dn_pc", o_pc, q[0].pc);
        check("dn_data", o_data, q[0].data);
      end else if (idle_known) begin
        check("idle_pc", o_pc, idle_pc);
        check("idle_data", o_data, idle_data);
      end
      if (!sel_skid) check("ready_rel", o_ready, !o_valid || dr);
      if (o_valid && dr) begin
        obs_delivered++;
        last_obs_pc = o_pc;
      end
    end
    last_acc = acc;
    @(posedge clk);
    if (!r) begin
      q.delete();
      model_ok   = 1;
      idle_known = 1;
      idle_pc    = '0;
      idle_data  = NOP;
    end else if (f) begin
      q.delete();
      idle_known = 1;
      idle_pc    = pc;
      idle_data  = NOP;
    end else begin
      if (xfer) void'(q.pop_front());
      if (acc) begin
        q.push_back('{pc: pc, data: d});
        idle_known = 0;
      end
    end
    @(negedge clk);
  endtask

  // Source holds a beat until it is accepted; pv/pr in percent, pf in per-mille.
  task automatic run(input int n, input int pv, input int pr, input int pf);
    for (int i = 0; i < n; i++) begin
      if (!src_valid && $urandom_range(99) < pv) begin
        src_valid = 1;
        src_pc    = next_pc;
        src_data  = $urandom;
        next_pc   = next_pc + 4;
      end
      cycle(1'b1, $urandom_range(999) < pf, src_valid, src_pc, src_data, $urandom_range(99) < pr);
      if (last_acc) src_valid = 0;
    end
  endtask

  initial begin
    sel_skid = 1; model_ok = 0; idle_known = 0; src_valid = 0;
    next_pc = 32'h100; obs_delivered = 0; last_obs_pc = '0;
    src_pc = '0; src_data = '0;
    rst = 1'b0; flush_i = 1'b0; up_valid_i = 1'b0; dn_ready_i = 1'b0;
    up_pc_i = '0; up_data_i = '0;
    @(negedge clk);

    cycle(1'b0, 1'b0, 1'b1, 32'h50, 32'hAAAA_5555, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'h54, 32'h1234_5678, 1'b1);

    obs_delivered = 0;
    run(16, 100, 100, 0);
    run(1, 0, 100, 0);
    check("stream_beats", obs_delivered, 16);

    run(4, 100, 0, 0);
    check("bp_count", count1, 2);
    check("bp_ready", up_ready1, 0);
    obs_delivered = 0;
    run(3, 0, 100, 0);
    check("bp_drain", obs_delivered, 3);

    run(3, 100, 0, 0);
    cycle(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0);
    check("flush_valid", dn_valid1, 0);
    check("flush_pc", dn_pc1, 32'h200);
    check("flush_data", dn_data1, NOP);
    check("flush_count", count1, 0);
    check("flush_ready", up_ready1, 1);
    run(10, 0, 100, 0);

    src_valid = 0;
    cycle(1'b1, 1'b0, 1'b1, 32'h300, 32'hC0DE_0300, 1'b0);
    obs_delivered = 0;
    cycle(1'b1, 1'b1, 1'b1, 32'h304, 32'hC0DE_0304, 1'b1);
    check("flush_xfer_pc", last_obs_pc, 32'h300);
    run(5, 0, 100, 0);
    check("flush_xfer_cnt", obs_delivered, 1);

    run(1500, 70, 60, 10);

    sel_skid = 0; model_ok = 0; src_valid = 0;
    cycle(1'b0, 1'b0, 1'b1, 32'h60, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h64, 32'h0, 1'b0);
    obs_delivered = 0;
    run(16, 100, 100, 0);
    run(1, 0, 100, 0);
    check("s0_stream_beats", obs_delivered, 16);
    run(1000, 70, 50, 0);
    run(400, 70, 50, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
